// File: rtl/stack_ctrl.sv
// stack_ctrl: game-logic core for the tower-stacking game.
// Slides the active block left/right at a divided tick rate and, on a drop
// request, trims it to its overlap with the block below, stacks it and logs
// its colour. Every output is registered; drop never reaches an output
// combinationally (drop in cycle N -> updated outputs in cycle N+2).
// Optional build macro STACK_SPEEDUP_EN: the tick divisor shrinks as the
// tower grows (TICK_DIV >> (height/4), never below 1), reloaded on each
// counter wrap; the counter is also cleared on every placement.
module stack_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int BASE_Y       = 360,
    parameter int BLOCK_H      = 20,
    parameter int BLOCK_W_INIT = 60,
    parameter int MAX_LEVELS   = 16,
    parameter int COLOR_W      = 2,
    parameter int TICK_DIV     = 250000,
    parameter int STEP         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drop,
    output logic [9:0]                    pos_x,
    output logic [9:0]                    pos_y,
    output logic [9:0]                    width,
    output logic [7:0]                    height,
    output logic [MAX_LEVELS*COLOR_W-1:0] colors,
    output logic                          placed,
    output logic                          game_over,
    output logic                          win,
    output logic [1:0]                    dbg_state
);

    localparam int          CW         = MAX_LEVELS * COLOR_W;
    localparam logic [10:0] SCREEN_W11 = 11'(SCREEN_W);
    localparam logic [10:0] STEP11     = 11'(STEP);
    localparam logic [9:0]  TOP_X_INIT = 10'((SCREEN_W - BLOCK_W_INIT) / 2);
    localparam logic [9:0]  POS_Y_INIT = 10'(BASE_Y - BLOCK_H);

    typedef enum logic [1:0] {
        S_MOVE  = 2'd0,
        S_PLACE = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [9:0]           pos_x_q, pos_x_d, pos_y_q, pos_y_d, width_q, width_d;
    logic [9:0]           top_x_q, top_x_d, top_w_q, top_w_d;
    logic [7:0]           height_q, height_d;
    logic [CW-1:0]        colors_q, colors_d;
    logic [COLOR_W-1:0]   next_col_q, next_col_d;
    logic                 dir_left_q, dir_left_d;
    logic                 placed_q, placed_d, game_over_q, game_over_d, win_q, win_d;
    logic [31:0]          tick_cnt_q, tick_cnt_d;
    logic [31:0]          div_cur;
    logic                 tick;

`ifdef STACK_SPEEDUP_EN
    logic [31:0] div_q, div_d, div_calc;
    assign div_cur = div_q;
    // Divisor for the current tower height, floored at 1
    always_comb begin
        div_calc = 32'(TICK_DIV) >> height_q[7:2];
        if (div_calc == 32'd0) div_calc = 32'd1;
    end
`else
    assign div_cur = 32'(TICK_DIV);
`endif

    assign tick = (tick_cnt_q == div_cur - 32'd1);

    // Overlap of the moving block with the top of the tower (11-bit, no wrap)
    logic [10:0] mv_l, mv_r, tp_l, tp_r, ov_l, ov_r, right_lim, px11;
    logic        miss, last_level;
    logic [7:0]  height_new;
    assign px11       = {1'b0, pos_x_q};
    assign mv_l       = px11;
    assign mv_r       = px11 + {1'b0, width_q};
    assign tp_l       = {1'b0, top_x_q};
    assign tp_r       = {1'b0, top_x_q} + {1'b0, top_w_q};
    assign ov_l       = (mv_l > tp_l) ? mv_l : tp_l;
    assign ov_r       = (mv_r < tp_r) ? mv_r : tp_r;
    assign miss       = (ov_r <= ov_l);
    assign height_new = height_q + 8'd1;
    assign last_level = (height_new == 8'(MAX_LEVELS));
    assign right_lim  = SCREEN_W11 - {1'b0, width_q};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_MOVE;
        else     state_q <= state_d;
    end

    // Next-state logic: PLACE lasts one cycle, OVER is left only by reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MOVE:  if (drop) state_d = S_PLACE;
            S_PLACE: state_d = (miss || last_level) ? S_OVER : S_MOVE;
            default: state_d = S_OVER;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        width_d     = width_q;
        top_x_d     = top_x_q;
        top_w_d     = top_w_q;
        height_d    = height_q;
        colors_d    = colors_q;
        next_col_d  = next_col_q;
        dir_left_d  = dir_left_q;
        placed_d    = 1'b0;
        game_over_d = game_over_q;
        win_d       = win_q;
        tick_cnt_d  = tick_cnt_q;
`ifdef STACK_SPEEDUP_EN
        div_d       = div_q;
`endif
        case (state_q)
            S_MOVE: begin
                tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
`ifdef STACK_SPEEDUP_EN
                if (tick) div_d = div_calc;
`endif
                // A drop freezes the block where it is, even on a tick
                if (tick && !drop) begin
                    if (!dir_left_q) begin
                        if (px11 + STEP11 >= right_lim) begin
                            pos_x_d    = right_lim[9:0];
                            dir_left_d = 1'b1;
                        end else begin
                            pos_x_d = 10'(px11 + STEP11);
                        end
                    end else begin
                        if (px11 <= STEP11) begin
                            pos_x_d    = 10'd0;
                            dir_left_d = 1'b0;
                        end else begin
                            pos_x_d = 10'(px11 - STEP11);
                        end
                    end
                end
            end
            S_PLACE: begin
                if (miss) begin
                    game_over_d = 1'b1;
                end else begin
                    top_x_d  = ov_l[9:0];
                    top_w_d  = 10'(ov_r - ov_l);
                    width_d  = 10'(ov_r - ov_l);
                    colors_d[int'(height_q)*COLOR_W +: COLOR_W] = next_col_q;
                    next_col_d = (next_col_q == COLOR_W'(3)) ? COLOR_W'(1)
                                                             : next_col_q + COLOR_W'(1);
                    height_d   = height_new;
                    placed_d   = 1'b1;
                    pos_x_d    = 10'd0;
                    dir_left_d = 1'b0;
                    pos_y_d    = 10'(BASE_Y - BLOCK_H * int'(height_new));
`ifdef STACK_SPEEDUP_EN
                    tick_cnt_d = 32'd0;
`endif
                    if (last_level) begin
                        game_over_d = 1'b1;
                        win_d       = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q     <= 10'd0;
            pos_y_q     <= POS_Y_INIT;
            width_q     <= 10'(BLOCK_W_INIT);
            top_x_q     <= TOP_X_INIT;
            top_w_q     <= 10'(BLOCK_W_INIT);
            height_q    <= 8'd1;
            colors_q    <= CW'(1);
            next_col_q  <= COLOR_W'(2);
            dir_left_q  <= 1'b0;
            placed_q    <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            tick_cnt_q  <= 32'd0;
`ifdef STACK_SPEEDUP_EN
            div_q       <= 32'(TICK_DIV);
`endif
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            width_q     <= width_d;
            top_x_q     <= top_x_d;
            top_w_q     <= top_w_d;
            height_q    <= height_d;
            colors_q    <= colors_d;
            next_col_q  <= next_col_d;
            dir_left_q  <= dir_left_d;
            placed_q    <= placed_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            tick_cnt_q  <= tick_cnt_d;
`ifdef STACK_SPEEDUP_EN
            div_q       <= div_d;
`endif
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign width     = width_q;
    assign height    = height_q;
    assign colors    = colors_q;
    assign placed    = placed_q;
    assign game_over = game_over_q;
    assign win       = win_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: table of reset/idle/drop steps with expected
// outputs on a default-geometry core, a bounce sequence on a narrow
// playfield, and a win plus asynchronous-reset sequence on a short tower.
module tb_stack_ctrl;

    logic clk, rst, drop;

    // Core A: default geometry, fast tick
    logic [9:0]  a_pos_x, a_pos_y, a_width;
    logic [7:0]  a_height;
    logic [31:0] a_colors;
    logic        a_placed, a_go, a_win;
    logic [1:0]  a_state;

    // Core B: narrow playfield, tick every cycle
    logic [9:0]  b_pos_x, b_pos_y, b_width;
    logic [7:0]  b_height;
    logic [31:0] b_colors;
    logic        b_placed, b_go, b_win;
    logic [1:0]  b_state;

    // Core C: three-level tower
    logic [9:0]  c_pos_x, c_pos_y, c_width;
    logic [7:0]  c_height;
    logic [5:0]  c_colors;
    logic        c_placed, c_go, c_win;
    logic [1:0]  c_state;

    stack_ctrl #(.TICK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .drop(drop),
        .pos_x(a_pos_x), .pos_y(a_pos_y), .width(a_width), .height(a_height),
        .colors(a_colors), .placed(a_placed), .game_over(a_go), .win(a_win),
        .dbg_state(a_state)
    );

    stack_ctrl #(.SCREEN_W(100), .BLOCK_W_INIT(60), .TICK_DIV(1), .STEP(1)) dut_b (
        .clk(clk), .rst(rst), .drop(drop),
        .pos_x(b_pos_x), .pos_y(b_pos_y), .width(b_width), .height(b_height),
        .colors(b_colors), .placed(b_placed), .game_over(b_go), .win(b_win),
        .dbg_state(b_state)
    );

    stack_ctrl #(.MAX_LEVELS(3), .TICK_DIV(4)) dut_c (
        .clk(clk), .rst(rst), .drop(drop),
        .pos_x(c_pos_x), .pos_y(c_pos_y), .width(c_width), .height(c_height),
        .colors(c_colors), .placed(c_placed), .game_over(c_go), .win(c_win),
        .dbg_state(c_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge only
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_drop();
        drop = 1'b1;
        cycle();
        drop = 1'b0;
        cycle();
    endtask

    typedef struct {
        bit          do_rst;
        int          idle;
        bit          do_drop;
        int          px, py, w, h;
        logic [31:0] col;
        bit          pl, go, wn;
    } vec_t;

    vec_t tbl[12];
    int   bounce_at[8];

    initial begin
        rst  = 1'b1;
        drop = 1'b0;
        @(negedge clk);

        // rst idle drop   pos_x pos_y width height colors  placed over win
        tbl[0]  = '{1, 0,    0, 0,   340, 60, 1, 32'h1,  0, 0, 0};
        tbl[1]  = '{0, 4,    0, 1,   340, 60, 1, 32'h1,  0, 0, 0};
        tbl[2]  = '{0, 8,    0, 3,   340, 60, 1, 32'h1,  0, 0, 0};
        tbl[3]  = '{0, 1148, 1, 0,   320, 60, 2, 32'h9,  1, 0, 0};  // exact at 290
        tbl[4]  = '{0, 1,    0, 0,   320, 60, 2, 32'h9,  0, 0, 0};
        tbl[5]  = '{0, 0,    1, 0,   320, 60, 2, 32'h9,  0, 1, 0};  // miss
        tbl[6]  = '{0, 20,   1, 0,   320, 60, 2, 32'h9,  0, 1, 0};  // ignored
        tbl[7]  = '{1, 0,    0, 0,   340, 60, 1, 32'h1,  0, 0, 0};
        tbl[8]  = '{0, 1240, 1, 0,   320, 40, 2, 32'h9,  1, 0, 0};  // partial at 310
        tbl[9]  = '{0, 1239, 1, 0,   300, 40, 3, 32'h39, 1, 0, 0};  // on trimmed top
        tbl[10] = '{1, 0,    1, 0,   340, 60, 1, 32'h1,  0, 1, 0};  // miss at 0
        tbl[11] = '{1, 0,    0, 0,   340, 60, 1, 32'h1,  0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_rst) apply_reset();
            repeat (tbl[i].idle) cycle();
            if (tbl[i].do_drop) do_drop();
            chk($sformatf("v%0d pos_x", i),     32'(a_pos_x),  32'(tbl[i].px));
            chk($sformatf("v%0d pos_y", i),     32'(a_pos_y),  32'(tbl[i].py));
            chk($sformatf("v%0d width", i),     32'(a_width),  32'(tbl[i].w));
            chk($sformatf("v%0d height", i),    32'(a_height), 32'(tbl[i].h));
            chk($sformatf("v%0d colors", i),    a_colors,      tbl[i].col);
            chk($sformatf("v%0d placed", i),    32'(a_placed), 32'(tbl[i].pl));
            chk($sformatf("v%0d game_over", i), 32'(a_go),     32'(tbl[i].go));
            chk($sformatf("v%0d win", i),       32'(a_win),    32'(tbl[i].wn));
        end

        // Bounce: right limit is 100-60=40, one step per cycle
        bounce_at = '{39, 40, 41, 60, 79, 80, 81, 82};
        exp_q = {};
        exp_q.push_back(39); exp_q.push_back(40); exp_q.push_back(39);
        exp_q.push_back(20); exp_q.push_back(1);  exp_q.push_back(0);
        exp_q.push_back(1);  exp_q.push_back(2);
        apply_reset();
        begin
            int n;
            n = 0;
            for (int i = 0; i < 8; i++) begin
                repeat (bounce_at[i] - n) cycle();
                n = bounce_at[i];
                chk($sformatf("bounce@%0d", n), 32'(b_pos_x), exp_q.pop_front());
            end
        end

        // Win on a three-level tower, then asynchronous reset in MOVE
        apply_reset();
        repeat (1160) cycle();
        do_drop();
        chk("win1 height", 32'(c_height), 32'd2);
        chk("win1 placed", 32'(c_placed), 32'd1);
        chk("win1 pos_y",  32'(c_pos_y),  32'd320);
        repeat (1159) cycle();
        do_drop();
        chk("win2 height",    32'(c_height), 32'd3);
        chk("win2 placed",    32'(c_placed), 32'd1);
        chk("win2 game_over", 32'(c_go),     32'd1);
        chk("win2 win",       32'(c_win),    32'd1);
        chk("win2 colors",    32'(c_colors), 32'h39);
        chk("win2 pos_y",     32'(c_pos_y),  32'd300);
        do_drop();
        chk("win3 height", 32'(c_height), 32'd3);
        chk("win3 placed", 32'(c_placed), 32'd0);
        chk("win3 win",    32'(c_win),    32'd1);
        apply_reset();
        chk("rst win",       32'(c_win),    32'd0);
        chk("rst game_over", 32'(c_go),     32'd0);
        chk("rst height",    32'(c_height), 32'd1);
        repeat (10) cycle();
        chk("pre-async pos_x", 32'(c_pos_x), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async pos_x",  32'(c_pos_x),  32'd0);
        chk("async pos_y",  32'(c_pos_y),  32'd340);
        chk("async width",  32'(c_width),  32'd60);
        chk("async colors", 32'(c_colors), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
